hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter RF_ADDR_WIDTH, default 5, register-address width.
REQ-002 SHALL have parameter MULT_CYCLES, default 4, multiply latency in cycles (minimum 2).
REQ-003 SHALL have parameter DIV_CYCLES, default 32, divide latency in cycles (minimum 2, at least MULT_CYCLES).
REQ-004 SHALL have ports:
  i_CLK  in  1  clock, single domain, rising edge.
  i_RST  in  1  reset, synchronous, active-low.
  i_RsD, i_RtD  in  RF_ADDR_WIDTH each  decode-stage source registers.
  i_RsE, i_RtE  in  RF_ADDR_WIDTH each  execute-stage source registers.
  i_WriteRegE, i_WriteRegM, i_WriteRegW  in  RF_ADDR_WIDTH each  destination register per stage.
  i_RegWriteE, i_RegWriteM, i_RegWriteW  in  1 each  register write enable per stage.
  i_MemtoRegE, i_MemtoRegM  in  1 each  load in E / M.
  i_BranchD  in  1  branch in decode.
  i_MDUOpD  in  1  mult/div in decode.
  i_MDUReadD  in  1  mfhi/mflo in decode.
  i_MDUStartE  in  1  mult/div issuing from E this cycle.
  i_MDUIsDivE  in  1  1 = divide, 0 = multiply (valid with i_MDUStartE).
  o_StallF, o_StallD, o_FlushE  out  1 each  pipeline stall and flush.
  o_ForwardAD, o_ForwardBD  out  1 each  decode comparator forward select (1 = ALUOutM).
  o_ForwardAE, o_ForwardBE  out  2 each  execute forward select (00 = RF, 01 = ResultW, 10 = ALUOutM).
  o_MDUBusy  out  1  MDU operation in flight.
  o_MDUDone  out  1  one-cycle pulse when the HI/LO result is valid.

Function
REQ-005 SHALL never match register 0 in any forwarding or hazard comparison.
REQ-006 SHALL drive o_ForwardAE = 10 when i_RegWriteM is set and i_WriteRegM equals i_RsE.
REQ-007 When REQ-006 does not apply, o_ForwardAE SHALL be 01 if i_RegWriteW is set and i_WriteRegW equals i_RsE, else 00; o_ForwardBE SHALL follow the same rule using i_RtE; M SHALL take priority over W.
REQ-008 SHALL drive o_ForwardAD = i_RegWriteM and (i_WriteRegM equals i_RsD); o_ForwardBD SHALL follow the same rule using i_RtD.
REQ-009 lwstall SHALL be i_MemtoRegE and (i_WriteRegE equals i_RsD or i_WriteRegE equals i_RtD).
REQ-010 branchstall SHALL be i_BranchD and either of:
  i_RegWriteE and i_WriteRegE in {i_RsD, i_RtD};
  i_MemtoRegM and i_WriteRegM in {i_RsD, i_RtD}.
REQ-011 mdustall SHALL be (i_MDUReadD or i_MDUOpD) while the sequencer state is BUSY.
REQ-012 o_StallF, o_StallD and o_FlushE SHALL each equal lwstall or branchstall or mdustall, combinationally in the same cycle.
REQ-013 The MDU sequencer SHALL have three states, IDLE, BUSY and DONE, plus a down-counter of width clog2(DIV_CYCLES).
REQ-014 From IDLE or DONE, i_MDUStartE SHALL move the sequencer to BUSY with counter = DIV_CYCLES-2 if i_MDUIsDivE, else MULT_CYCLES-2.
REQ-015 In BUSY the counter SHALL decrement each cycle; at counter 0 the next state SHALL be DONE.
REQ-016 DONE SHALL last one cycle and then go to IDLE, unless a new start occurs (REQ-014).
REQ-017 Total start-to-DONE latency SHALL be exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-018 o_MDUBusy SHALL be 1 in BUSY only; o_MDUDone SHALL be 1 in DONE only.
REQ-019 An mfhi/mflo decoded in DONE SHALL NOT stall.
REQ-020 i_MDUStartE while BUSY SHALL be ignored and flagged by a simulation assertion; by construction REQ-011 prevents it.

Reset
REQ-021 When i_RST = 0 at a clock edge, the state SHALL become IDLE and the counter 0, so o_MDUBusy = 0 and o_MDUDone = 0 on the next cycle.
REQ-022 A reset during BUSY SHALL abort the operation with no o_MDUDone pulse.
REQ-023 Combinational outputs SHALL depend only on the inputs and the registered state.

Structure
REQ-024 A shared package hazard_pkg SHALL hold the state encoding (IDLE = 00, BUSY = 01, DONE = 10) and the forward-select constants FWD_RF, FWD_WB and FWD_MEM.
REQ-025 The sequencer (REQ-013 to REQ-022) SHALL be a sub-module named mdu_seq; hazard_ctrl SHALL contain only the comparison and stall logic plus one mdu_seq instance.

Verification
REQ-026 Inputs RsE = 3, RegWriteM = 1, WriteRegM = 3, RegWriteW = 1, WriteRegW = 3 -> ForwardAE = 10; with WriteRegM = 0 instead -> ForwardAE = 01.
REQ-027 Inputs MemtoRegE = 1, WriteRegE = 8, RtD = 8 -> StallF = StallD = FlushE = 1 for exactly one cycle once E advances.
REQ-028 Inputs BranchD = 1, RsD = 5, RegWriteE = 1, WriteRegE = 5 -> stall; next cycle MemtoRegM = 0 and RegWriteM = 1 with WriteRegM = 5 -> no stall and ForwardAD = 1.
REQ-029 MDUStartE with IsDivE = 0 at cycle t -> Busy for cycles t+1 to t+3, Done at t+4; MDUReadD held from t+1 -> stall for cycles t+1 to t+3, released at t+4.
REQ-030 Divide start, then i_RST = 0 at cycle t+10 -> Busy = 0 from t+11 and no Done pulse ever.
REQ-031 RsD = RtD = 0, with all WriteReg = 0 and all RegWrite = 1 -> every forward select 0 and no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: MDU sequencer state
// encoding and execute-stage forward-select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// mdu_seq: tracks an in-flight mult/div. Ports: clk, rst_n (sync,
// active-low), start, is_div in; busy, done (registered) out.
module mdu_seq
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(DIV_CYCLES);

  // One cycle is spent in DONE, one leaving IDLE: load latency-2.
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 2);

  mdu_state_t    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_BUSY;
            cnt   <= is_div ? DIV_LOAD : MULT_LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ST_BUSY: begin
          // A start here is dropped; decode stalls should prevent it.
          if (cnt == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  start_while_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(start && state == ST_BUSY)
  );

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects plus load/branch/MDU stall logic.
// In: D/E sources, per-stage dest + write enables, load/branch/MDU
// flags. Out: StallF/StallD/FlushE, forward selects, MDU busy/done.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int MULT_CYCLES   = 4,
  parameter int DIV_CYCLES    = 32
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                     i_RegWriteE,
  input  logic                     i_RegWriteM,
  input  logic                     i_RegWriteW,
  input  logic                     i_MemtoRegE,
  input  logic                     i_MemtoRegM,
  input  logic                     i_BranchD,
  input  logic                     i_MDUOpD,
  input  logic                     i_MDUReadD,
  input  logic                     i_MDUStartE,
  input  logic                     i_MDUIsDivE,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_FlushE,
  output logic                     o_ForwardAD,
  output logic                     o_ForwardBD,
  output logic [1:0]               o_ForwardAE,
  output logic [1:0]               o_ForwardBE,
  output logic                     o_MDUBusy,
  output logic                     o_MDUDone
);

  typedef logic [RF_ADDR_WIDTH-1:0] reg_t;

  // $zero is never a real producer.
  function automatic logic hit(input reg_t dst, input reg_t src);
    return (src != '0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input reg_t src);
    logic [1:0] sel;
    if (i_RegWriteM && hit(i_WriteRegM, src))
      sel = FWD_MEM;
    else if (i_RegWriteW && hit(i_WriteRegW, src))
      sel = FWD_WB;
    else
      sel = FWD_RF;
    return sel;
  endfunction

  logic lw_stall;
  logic br_stall;
  logic mdu_stall;
  logic stall;
  logic e_hit;
  logic m_hit;
  logic mdu_busy;
  logic mdu_done;

  always_comb begin
    o_ForwardAE = fwd_sel(i_RsE);
    o_ForwardBE = fwd_sel(i_RtE);
  end

  assign o_ForwardAD = i_RegWriteM && hit(i_WriteRegM, i_RsD);
  assign o_ForwardBD = i_RegWriteM && hit(i_WriteRegM, i_RtD);

  assign e_hit = hit(i_WriteRegE, i_RsD) || hit(i_WriteRegE, i_RtD);
  assign m_hit = hit(i_WriteRegM, i_RsD) || hit(i_WriteRegM, i_RtD);

  assign lw_stall  = i_MemtoRegE && e_hit;
  assign br_stall  = i_BranchD &&
                     ((i_RegWriteE && e_hit) ||
                      (i_MemtoRegM && m_hit));
  assign mdu_stall = (i_MDUReadD || i_MDUOpD) && mdu_busy;

  assign stall    = lw_stall || br_stall || mdu_stall;
  assign o_StallF = stall;
  assign o_StallD = stall;
  assign o_FlushE = stall;

  mdu_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_seq (
    .clk    (i_CLK),
    .rst_n  (i_RST),
    .start  (i_MDUStartE),
    .is_div (i_MDUIsDivE),
    .busy   (mdu_busy),
    .done   (mdu_done)
  );

  assign o_MDUBusy = mdu_busy;
  assign o_MDUDone = mdu_done;

endmodule
